// File: rtl/fifo_sync_flags.sv
// Single-clock FIFO with programmable almost-full/almost-empty flags, optional
// first-word-fall-through read mode, read-valid strobe and sticky error flags.
module fifo_sync_flags #(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned DEPTH     = 16,
  parameter int unsigned FWFT      = 0,
  parameter int unsigned AF_THRESH = DEPTH - 2,
  parameter int unsigned AE_THRESH = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_en,
  input  logic [WIDTH-1:0]         din,
  input  logic                     rd_en,
  output logic [WIDTH-1:0]         dout,
  output logic                     rd_valid,
  output logic                     full,
  output logic                     empty,
  output logic                     almost_full,
  output logic                     almost_empty,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     overflow,
  output logic                     underflow,
  input  logic                     clr_err
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = AW + 1;

  localparam logic [LW-1:0] DepthLvl = LW'(DEPTH);
  localparam logic [LW-1:0] AfLvl    = LW'(AF_THRESH);
  localparam logic [LW-1:0] AeLvl    = LW'(AE_THRESH);

  logic [WIDTH-1:0] mem_q [DEPTH];

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [LW-1:0] level_q, level_d;
  logic          overflow_q, overflow_d;
  logic          underflow_q, underflow_d;
  logic          rd_acc, wr_acc;

  // Flags decode the registered level only, so they never glitch on inputs.
  assign empty        = (level_q == '0);
  assign full         = (level_q == DepthLvl);
  assign almost_full  = (level_q >= AfLvl);
  assign almost_empty = (level_q <= AeLvl);
  assign level        = level_q;
  assign overflow     = overflow_q;
  assign underflow    = underflow_q;

  // A write at full is still taken when a read frees a slot in the same cycle.
  assign rd_acc = rd_en && !empty;
  assign wr_acc = wr_en && (!full || rd_acc);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (wr_acc) wr_ptr_d = wr_ptr_q + AW'(1);
    if (rd_acc) rd_ptr_d = rd_ptr_q + AW'(1);
    unique case ({wr_acc, rd_acc})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase
  end

  // A fresh error in the clearing cycle keeps the flag set.
  always_comb begin
    overflow_d  = (overflow_q  && !clr_err) || (wr_en && !wr_acc);
    underflow_d = (underflow_q && !clr_err) || (rd_en && !rd_acc);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      level_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      level_q     <= level_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  // Storage is deliberately not reset; pointers and level define what is valid.
  always_ff @(posedge clk) begin
    if (wr_acc) mem_q[wr_ptr_q] <= din;
  end

  if (FWFT != 0) begin : g_fwft
    assign dout     = mem_q[rd_ptr_q];
    assign rd_valid = !empty;
  end else begin : g_std
    logic [WIDTH-1:0] dout_q, dout_d;
    logic             rd_valid_q, rd_valid_d;

    always_comb begin
      dout_d     = dout_q;
      rd_valid_d = rd_acc;
      if (rd_acc) dout_d = mem_q[rd_ptr_q];
    end

    always_ff @(posedge clk) begin
      if (!rst) begin
        dout_q     <= '0;
        rd_valid_q <= 1'b0;
      end else begin
        dout_q     <= dout_d;
        rd_valid_q <= rd_valid_d;
      end
    end

    assign dout     = dout_q;
    assign rd_valid = rd_valid_q;
  end

endmodule
